// File: rtl/song_reader.sv
// song_reader: walks the note table of the selected song in a synchronous
// note ROM, issuing one note at a time to the note player.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   play        1 = fetch and issue notes, 0 = hold in IDLE
//   song        song select, upper bits of the ROM address
//   reset_play  synchronous restart of the current song (level, highest priority)
//   note_done   one-cycle pulse from the note player when the note has ended
//   rom_addr    {song, idx}, combinational
//   rom_data    {note, duration}, valid one cycle after rom_addr
//   note        registered note code of the current note
//   duration    registered duration of the current note
//   new_note    one-cycle strobe, note/duration are fresh
//   song_done   one-cycle pulse at end of song
module song_reader #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic [1:0]              song,
  input  logic                    reset_play,
  input  logic                    note_done,
  output logic [IDX_W+1:0]        rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    new_note,
  output logic                    song_done
);

  localparam int unsigned ROM_W = NOTE_W + DUR_W;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CHECK = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                new_note_q, new_note_d;
  logic                song_done_q, song_done_d;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  assign rom_note = rom_data[ROM_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // ROM address tracks song and index directly so the word is ready in CHECK
  assign rom_addr = {song, idx_q};

  // Next-state and output decode; strobes default low so they last one cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (rom_dur == '0) begin
          // Zero duration marks end of song; keep the last note on the outputs
          song_done_d = 1'b1;
          idx_d       = '0;
          state_d     = S_IDLE;
        end else begin
          note_d     = rom_note;
          dur_d      = rom_dur;
          new_note_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (note_done) begin
          // Index wraps naturally; a full table ends the song without a marker
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_IDLE;
          if (idx_q == IDX_LAST) begin
            song_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Restart wins over everything decoded above, including end of song
    if (reset_play) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      note_d      = '0;
      dur_d       = '0;
      new_note_d  = 1'b0;
      song_done_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed bench for song_reader with a behavioural
// synchronous note ROM and a queue of expected {note, duration} words.
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        reset_play;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] rom [128];
  logic [11:0] exp_q [$];

  int vectors     = 0;
  int miscompares = 0;

  song_reader dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song       (song),
    .reset_play (reset_play),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .song_done  (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous note ROM: word appears one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // new_note must rise exactly lat cycles from now, carry the next expected
  // word, and drop again one cycle later
  task automatic expect_note(input int lat);
    logic [11:0] e;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k < lat) chk("early_strobe", 32'(new_note), 32'd0);
    end
    chk("new_note", 32'(new_note), 32'd1);
    chk("no_done_with_note", 32'(song_done), 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
    chk("note", 32'(note), 32'(e[11:6]));
    chk("duration", 32'(duration), 32'(e[5:0]));
    tick();
    chk("strobe_width", 32'(new_note), 32'd0);
  endtask

  // song_done must rise exactly lat cycles from now with no note strobe
  task automatic expect_song_done(input int lat);
    for (int k = 1; k <= lat; k++) begin
      tick();
      chk("no_note_at_end", 32'(new_note), 32'd0);
      if (k < lat) chk("early_song_done", 32'(song_done), 32'd0);
    end
    chk("song_done", 32'(song_done), 32'd1);
  endtask

  task automatic pulse_done;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
  endtask

  task automatic restart(input logic [1:0] s);
    song       = s;
    reset_play = 1'b1;
    tick();
    reset_play = 1'b0;
  endtask

  // The two strobes must never coincide
  always @(negedge clk) begin
    if (reset) chk("strobe_exclusive", 32'(new_note & song_done), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 12'hfff;
    rom[0] = {6'h12, 6'd3};
    rom[1] = {6'h13, 6'd4};
    rom[2] = {6'h14, 6'd5};
    rom[3] = {6'h00, 6'd0};
    rom[32] = {6'h05, 6'h10};
    rom[33] = {6'h06, 6'h11};
    rom[34] = {6'h00, 6'd0};
    for (int i = 0; i < 32; i++) begin
      rom[64 + i] = {6'(i + 1), 6'(i + 1)};
      rom[96 + i] = {6'(i ^ 21), 6'(i + 2)};
    end

    reset      = 1'b0;
    play       = 1'b0;
    song       = 2'd0;
    reset_play = 1'b0;
    note_done  = 1'b0;
    tick();
    tick();
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_duration", 32'(duration), 32'd0);
    chk("rst_new_note", 32'(new_note), 32'd0);
    chk("rst_song_done", 32'(song_done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h00);
    reset = 1'b1;
    tick();

    // Async reset in the middle of a note
    play = 1'b1;
    exp_q.push_back(rom[0]);
    expect_note(3);
    chk("pre_reset_note", 32'(note), 32'h12);
    play  = 1'b0;
    reset = 1'b0;
    tick();
    chk("areset_note", 32'(note), 32'd0);
    chk("areset_duration", 32'(duration), 32'd0);
    chk("areset_new_note", 32'(new_note), 32'd0);
    chk("areset_song_done", 32'(song_done), 32'd0);
    chk("areset_rom_addr", 32'(rom_addr), 32'h00);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_no_note", 32'(new_note), 32'd0);
      chk("idle_no_done", 32'(song_done), 32'd0);
    end

    // End marker: three notes then song_done
    play = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rom[i]);
      expect_note(3);
      pulse_done();
    end
    expect_song_done(3);
    play = 1'b0;
    chk("end_rom_addr", 32'(rom_addr), 32'h00);
    tick();
    chk("end_done_width", 32'(song_done), 32'd0);
    tick();
    chk("end_idle", 32'(new_note), 32'd0);

    // Basic issue on song 1 with back-to-back latency
    song = 2'd1;
    tick();
    chk("song1_addr0", 32'(rom_addr), 32'h20);
    play = 1'b1;
    exp_q.push_back(rom[32]);
    expect_note(3);
    pulse_done();
    chk("song1_addr1", 32'(rom_addr), 32'h21);
    exp_q.push_back(rom[33]);
    expect_note(3);
    pulse_done();
    expect_song_done(3);
    play = 1'b0;
    chk("song1_end_addr", 32'(rom_addr), 32'h20);
    tick();

    // Pause: play low in WAIT lets idx advance but blocks the next fetch
    restart(2'd1);
    play = 1'b1;
    exp_q.push_back(rom[32]);
    expect_note(3);
    play = 1'b0;
    tick();
    tick();
    pulse_done();
    chk("pause_addr", 32'(rom_addr), 32'h21);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pause_no_note", 32'(new_note), 32'd0);
      chk("pause_addr_hold", 32'(rom_addr), 32'h21);
    end
    play = 1'b1;
    exp_q.push_back(rom[33]);
    expect_note(3);
    play = 1'b0;
    restart(2'd1);
    chk("restart_note", 32'(note), 32'd0);
    chk("restart_duration", 32'(duration), 32'd0);

    // Full table wrap on song 2
    restart(2'd2);
    chk("song2_addr0", 32'(rom_addr), 32'h40);
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(rom[64 + i]);
      expect_note(3);
      pulse_done();
    end
    chk("wrap_song_done", 32'(song_done), 32'd1);
    chk("wrap_rom_addr", 32'(rom_addr), 32'h40);
    play = 1'b0;
    tick();
    chk("wrap_done_width", 32'(song_done), 32'd0);
    chk("wrap_no_note", 32'(new_note), 32'd0);

    // reset_play beats note_done at the last slot
    restart(2'd3);
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(rom[96 + i]);
      expect_note(3);
      if (i < 31) pulse_done();
    end
    chk("rp_addr31", 32'(rom_addr), 32'h7f);
    note_done  = 1'b1;
    reset_play = 1'b1;
    tick();
    note_done  = 1'b0;
    reset_play = 1'b0;
    play       = 1'b0;
    chk("rp_song_done", 32'(song_done), 32'd0);
    chk("rp_new_note", 32'(new_note), 32'd0);
    chk("rp_note", 32'(note), 32'd0);
    chk("rp_duration", 32'(duration), 32'd0);
    chk("rp_rom_addr", 32'(rom_addr), 32'h60);
    tick();
    chk("rp_no_late_done", 32'(song_done), 32'd0);
    pulse_done();
    chk("stray_addr", 32'(rom_addr), 32'h60);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stray_no_note", 32'(new_note), 32'd0);
      chk("stray_no_done", 32'(song_done), 32'd0);
      chk("stray_addr_hold", 32'(rom_addr), 32'h60);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
